keypad_code_lock: RTL and testbench

//  Parametrised keypad code-lock controller: consumes debounced key events from the keypad decoder,

---
 rtl/keypad_code_lock_pkg.sv | 25 ++
 rtl/keypad_code_lock_if.sv | 39 +++
 rtl/keypad_code_lock_timer.sv | 24 ++
 rtl/keypad_code_lock.sv | 197 +++++++++++++++++++
 tb/tb_keypad_code_lock.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/keypad_code_lock_pkg.sv
// Shared types and key decoding helpers for the keypad code lock.
package lock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_CHECK,
        ST_UNLOCKED,
        ST_LOCKOUT
    } lock_state_t;

    localparam logic [3:0] KEY_CLR = 4'hE;
    localparam logic [3:0] KEY_ENT = 4'hF;

    function automatic logic is_digit(input logic [7:0] key);
        return key <= 8'd9;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/keypad_code_lock_if.sv
// Key-event and status bundle between the keypad front end and the code lock.
// Optional code programming ports appear when LOCK_CODE_PROG_EN is defined.
interface keypad_code_lock_if #(
    parameter int DIGITS   = 4,
    parameter int KEY_W    = 4,
    parameter int MAX_FAIL = 3
);
    localparam int CNT_W  = $clog2(DIGITS + 1);
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);

    logic              key_valid;
    logic [KEY_W-1:0]  key_code;
    logic              unlock;
    logic              entry_full;
    logic              locked_out;
    logic              bad_code;
    logic [CNT_W-1:0]  digit_count;
    logic [FAIL_W-1:0] fail_count;
`ifdef LOCK_CODE_PROG_EN
    logic                      prog_we;
    logic [DIGITS*KEY_W-1:0]   prog_code;
`endif

    modport master (
        output key_valid, key_code,
`ifdef LOCK_CODE_PROG_EN
        output prog_we, prog_code,
`endif
        input  unlock, entry_full, locked_out, bad_code, digit_count, fail_count
    );

    modport slave (
        input  key_valid, key_code,
`ifdef LOCK_CODE_PROG_EN
        input  prog_we, prog_code,
`endif
        output unlock, entry_full, locked_out, bad_code, digit_count, fail_count
    );
endinterface

// File: rtl/keypad_code_lock_timer.sv
// Shared down-counter: loadable, holds at zero, flags the cycle it reaches zero.
module lock_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);
    logic [W-1:0] value;

    always_ff @(posedge clk) begin
        if (rst)
            value <= '0;
        else if (load)
            value <= load_val;
        else if (value != '0)
            value <= value - W'(1);
    end

    // A load of N therefore expires on the N-th following edge.
    assign expire = (value == W'(1));
endmodule

// File: rtl/keypad_code_lock.sv
// Keypad code-lock controller: code entry, check, timed unlock and lockout.
// Define LOCK_CODE_PROG_EN to make the code reprogrammable while unlocked.
module keypad_code_lock
    import lock_pkg::*;
#(
    parameter int                      DIGITS      = 4,
    parameter int                      KEY_W       = 4,
    parameter logic [DIGITS*KEY_W-1:0] CODE        = 16'h1234,
    parameter int                      MAX_FAIL    = 3,
    parameter int                      UNLOCK_CYC  = 100,
    parameter int                      LOCKOUT_CYC = 1000,
    parameter int                      TIMEOUT_CYC = 500
) (
    input  logic               clk,
    input  logic               rst,
    keypad_code_lock_if.slave  bus
);
    localparam int CODE_W = DIGITS * KEY_W;
    localparam int CNT_W  = $clog2(DIGITS + 1);
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int TMR_W  = $clog2(max3(UNLOCK_CYC, LOCKOUT_CYC, TIMEOUT_CYC) + 1);

    logic              key_valid_p0;
    logic [KEY_W-1:0]  key_code_p0;
    lock_state_t       state, state_n;
    logic [CODE_W-1:0] buffer, buffer_n;
    logic [CNT_W-1:0]  count, count_n;
    logic              ovf, ovf_n;
    logic [FAIL_W-1:0] fail, fail_n, fail_inc;
    logic              unlock_q, unlock_n;
    logic              locked_q, locked_n;
    logic              bad_q, bad_n;
    logic              tmr_load, tmr_expire;
    logic [TMR_W-1:0]  tmr_val;
    logic [CODE_W-1:0] code_cur;
    logic              is_dig, is_clr, is_ent, match;

`ifdef LOCK_CODE_PROG_EN
    logic [CODE_W-1:0] code_q, code_n;
    assign code_cur = code_q;
`else
    assign code_cur = CODE;
`endif

    lock_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    // Stage p0: register the key event from the decoder
    always_ff @(posedge clk) begin
        if (rst)
            key_valid_p0 <= 1'b0;
        else
            key_valid_p0 <= bus.key_valid;
        key_code_p0 <= bus.key_code;
    end

    assign is_dig   = key_valid_p0 && is_digit(8'(key_code_p0));
    assign is_clr   = key_valid_p0 && (key_code_p0 == KEY_W'(KEY_CLR));
    assign is_ent   = key_valid_p0 && (key_code_p0 == KEY_W'(KEY_ENT));
    assign match    = (count == CNT_W'(DIGITS)) && !ovf && (buffer == code_cur);
    assign fail_inc = fail + FAIL_W'(1);

    always_comb begin
        state_n  = state;
        buffer_n = buffer;
        count_n  = count;
        ovf_n    = ovf;
        fail_n   = fail;
        unlock_n = unlock_q;
        locked_n = locked_q;
        bad_n    = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
`ifdef LOCK_CODE_PROG_EN
        code_n   = code_q;
`endif
        case (state)
            ST_IDLE: begin
                if (is_dig) begin
                    buffer_n = CODE_W'(key_code_p0);
                    count_n  = CNT_W'(1);
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(TIMEOUT_CYC);
                    state_n  = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                // A key in the expiry cycle takes priority over the timeout.
                if (key_valid_p0) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(TIMEOUT_CYC);
                    if (is_dig) begin
                        if (count < CNT_W'(DIGITS)) begin
                            buffer_n = (buffer << KEY_W) | CODE_W'(key_code_p0);
                            count_n  = count + CNT_W'(1);
                        end else begin
                            ovf_n = 1'b1;
                        end
                    end else if (is_clr) begin
                        buffer_n = '0;
                        count_n  = '0;
                        ovf_n    = 1'b0;
                        state_n  = ST_IDLE;
                    end else if (is_ent) begin
                        state_n  = ST_CHECK;
                    end
                end else if (tmr_expire) begin
                    buffer_n = '0;
                    count_n  = '0;
                    ovf_n    = 1'b0;
                    state_n  = ST_IDLE;
                end
            end
            ST_CHECK: begin
                buffer_n = '0;
                count_n  = '0;
                ovf_n    = 1'b0;
                tmr_load = 1'b1;
                if (match) begin
                    fail_n   = '0;
                    unlock_n = 1'b1;
                    tmr_val  = TMR_W'(UNLOCK_CYC);
                    state_n  = ST_UNLOCKED;
                end else begin
                    bad_n  = 1'b1;
                    fail_n = fail_inc;
                    if (fail_inc == FAIL_W'(MAX_FAIL)) begin
                        locked_n = 1'b1;
                        tmr_val  = TMR_W'(LOCKOUT_CYC);
                        state_n  = ST_LOCKOUT;
                    end else begin
                        state_n  = ST_IDLE;
                    end
                end
            end
            ST_UNLOCKED: begin
`ifdef LOCK_CODE_PROG_EN
                if (bus.prog_we)
                    code_n = bus.prog_code;
`endif
                if (is_clr || tmr_expire) begin
                    unlock_n = 1'b0;
                    state_n  = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                if (tmr_expire) begin
                    fail_n   = '0;
                    locked_n = 1'b0;
                    state_n  = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Stage p1: FSM state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            buffer   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            fail     <= '0;
            unlock_q <= 1'b0;
            locked_q <= 1'b0;
            bad_q    <= 1'b0;
`ifdef LOCK_CODE_PROG_EN
            code_q   <= CODE;
`endif
        end else begin
            state    <= state_n;
            buffer   <= buffer_n;
            count    <= count_n;
            ovf      <= ovf_n;
            fail     <= fail_n;
            unlock_q <= unlock_n;
            locked_q <= locked_n;
            bad_q    <= bad_n;
`ifdef LOCK_CODE_PROG_EN
            code_q   <= code_n;
`endif
        end
    end

    assign bus.unlock      = unlock_q;
    assign bus.locked_out  = locked_q;
    assign bus.bad_code    = bad_q;
    assign bus.digit_count = count;
    assign bus.fail_count  = fail;
    assign bus.entry_full  = (count == CNT_W'(DIGITS));
endmodule

// File: tb/tb_keypad_code_lock.sv
// Directed bench for keypad_code_lock with default parameters (code 1234).
// Define LOCK_CODE_PROG_EN to also exercise code programming.
module tb_keypad_code_lock;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   n;

    always #5 clk = ~clk;

    keypad_code_lock_if #(.DIGITS(4), .KEY_W(4), .MAX_FAIL(3)) bus ();

    keypad_code_lock dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = k;
        @(negedge clk);
        bus.key_valid = 1'b0;
    endtask

    task automatic press_code(input logic [15:0] c);
        for (int i = 3; i >= 0; i--) press(c[i*4 +: 4]);
        press(4'hF);
    endtask

    // Count consecutive samples with unlock (sel=0) or locked_out (sel=1) high.
    task automatic count_high(input bit sel, output int cnt);
        cnt = 1;
        while (((sel ? bus.locked_out : bus.unlock) === 1'b1) && cnt < 3000) begin
            tick(1);
            if ((sel ? bus.locked_out : bus.unlock) === 1'b1) cnt++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
`ifdef LOCK_CODE_PROG_EN
        bus.prog_we   = 1'b0;
        bus.prog_code = 16'h0;
`endif
        tick(3);
        rst = 1'b0;
        check("rst_unlock", 32'(bus.unlock), 0);
        check("rst_locked", 32'(bus.locked_out), 0);
        check("rst_bad", 32'(bus.bad_code), 0);
        check("rst_full", 32'(bus.entry_full), 0);
        check("rst_digits", 32'(bus.digit_count), 0);
        check("rst_fails", 32'(bus.fail_count), 0);

        // Correct code: unlock two edges after ENT is sampled, held 100 cycles
        press(4'h1); press(4'h2); press(4'h3); press(4'h4);
        tick(1);
        check("t1_digits", 32'(bus.digit_count), 4);
        check("t1_full", 32'(bus.entry_full), 1);
        press(4'hF);
        tick(1);
        check("t1_unlock_early", 32'(bus.unlock), 0);
        tick(1);
        check("t1_unlock", 32'(bus.unlock), 1);
        check("t1_fails", 32'(bus.fail_count), 0);
        check("t1_digits_clr", 32'(bus.digit_count), 0);
        count_high(1'b0, n);
        check("t1_unlock_len", 32'(n), 100);

        // Wrong code
        press_code(16'h1235);
        tick(1);
        check("t2_bad_early", 32'(bus.bad_code), 0);
        tick(1);
        check("t2_bad", 32'(bus.bad_code), 1);
        check("t2_fails", 32'(bus.fail_count), 1);
        check("t2_unlock", 32'(bus.unlock), 0);
        tick(1);
        check("t2_bad_pulse", 32'(bus.bad_code), 0);

        // Two more failures -> lockout; keys during lockout are ignored
        press(4'h9); press(4'hF); tick(2);
        check("t3_fails2", 32'(bus.fail_count), 2);
        check("t3_locked_no", 32'(bus.locked_out), 0);
        press(4'h9); press(4'hF); tick(2);
        check("t3_locked", 32'(bus.locked_out), 1);
        check("t3_fails3", 32'(bus.fail_count), 3);
        check("t3_bad", 32'(bus.bad_code), 1);
        press_code(16'h1234);
        check("t3_ignored", 32'(bus.digit_count), 0);
        count_high(1'b1, n);
        check("t3_lock_len", 32'(n + 10), 1000);
        check("t3_fails_clr", 32'(bus.fail_count), 0);
        check("t3_unlock", 32'(bus.unlock), 0);

        // Overflow entry rejected, then clear and retry
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5); press(4'hF);
        tick(2);
        check("t4_bad", 32'(bus.bad_code), 1);
        check("t4_fails", 32'(bus.fail_count), 1);
        check("t4_unlock", 32'(bus.unlock), 0);
        press(4'h1); press(4'h2); press(4'hE);
        tick(1);
        check("t4_clr_digits", 32'(bus.digit_count), 0);
        check("t4_clr_fails", 32'(bus.fail_count), 1);
        press_code(16'h1234);
        tick(2);
        check("t4_unlock", 32'(bus.unlock), 1);
        check("t4_fails_clr", 32'(bus.fail_count), 0);
        press(4'hE);
        tick(1);
        check("t4_relock", 32'(bus.unlock), 0);

        // Entry timeout: discard on the 500th idle cycle, a key on it keeps entry
        press(4'h1);
        tick(1);
        check("t5_digits1", 32'(bus.digit_count), 1);
        tick(499);
        check("t5_before_to", 32'(bus.digit_count), 1);
        tick(1);
        check("t5_timeout", 32'(bus.digit_count), 0);
        check("t5_fails", 32'(bus.fail_count), 0);
        press(4'h1);
        tick(1);
        tick(497);
        press(4'h2);
        tick(1);
        check("t5_key_wins", 32'(bus.digit_count), 2);
        press(4'hE);
        tick(1);

        // Reset mid-lockout and mid-unlock
        for (int i = 0; i < 3; i++) begin
            press(4'h9); press(4'hF); tick(2);
        end
        tick(50);
        check("t6_locked", 32'(bus.locked_out), 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t6_rst_locked", 32'(bus.locked_out), 0);
        check("t6_rst_fails", 32'(bus.fail_count), 0);
        check("t6_rst_bad", 32'(bus.bad_code), 0);
        press_code(16'h1234);
        tick(2);
        check("t6_unlock", 32'(bus.unlock), 1);
        tick(20);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t6_rst_unlock", 32'(bus.unlock), 0);
        check("t6_rst_digits", 32'(bus.digit_count), 0);

`ifdef LOCK_CODE_PROG_EN
        press_code(16'h1234);
        tick(2);
        check("p_unlock", 32'(bus.unlock), 1);
        @(negedge clk);
        bus.prog_we = 1'b1;
        bus.prog_code = 16'h4321;
        @(negedge clk);
        bus.prog_we = 1'b0;
        press(4'hE);
        tick(1);
        press_code(16'h4321);
        tick(2);
        check("p_new_code", 32'(bus.unlock), 1);
        press(4'hE);
        tick(1);
        press_code(16'h1234);
        tick(2);
        check("p_old_bad", 32'(bus.bad_code), 1);
        check("p_old_unlock", 32'(bus.unlock), 0);
        @(negedge clk);
        bus.prog_we = 1'b1;
        bus.prog_code = 16'h1111;
        @(negedge clk);
        bus.prog_we = 1'b0;
        press_code(16'h4321);
        tick(2);
        check("p_idle_ignored", 32'(bus.unlock), 1);
        press(4'hE);
        tick(1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
